// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with scoreboard of pending writes and self-clearing init
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset, restarts the clear sequence
//   ready            1 once every register has been zeroed (RUN state)
//   a1, a2           read addresses; rd1, rd2 combinational read data (with write bypass)
//   busy1, busy2     register at a1 / a2 has an outstanding write
//   we3, a3, wd3     write port
//   iss_v, iss_rd    issue port: mark iss_rd as pending
//   pend_cnt         number of pending registers (registered)
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic [$clog2(NREG)-1:0] a1,
  input  logic [$clog2(NREG)-1:0] a2,
  output logic [XLEN-1:0]        rd1,
  output logic [XLEN-1:0]        rd2,
  output logic                   busy1,
  output logic                   busy2,
  input  logic                   we3,
  input  logic [$clog2(NREG)-1:0] a3,
  input  logic [XLEN-1:0]        wd3,
  input  logic                   iss_v,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  output logic [$clog2(NREG):0]  pend_cnt
);

  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pend, pend_nxt;
  logic [AW:0]     cnt_nxt;

  // Writes that actually land: register 0 is hardwired, so writes/issues to it vanish.
  logic wr_en, iss_en;
  assign wr_en  = (state == RUN) && we3 && (a3 != '0);
  assign iss_en = (state == RUN) && iss_v && (iss_rd != '0);

  assign ready = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == AW'(NREG - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Clear is applied before set so an issue and a writeback to the same
  // register in one cycle leaves it pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_en)  pend_nxt[a3]     = 1'b0;
    if (iss_en) pend_nxt[iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= AW'(1);
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      state    <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Storage has no reset; it is zeroed one entry per cycle by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (wr_en) begin
        mem[a3] <= wd3;
      end
    end
  end

  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (state == RUN) begin
      if (a1 != '0) begin
        rd1   = (we3 && (a3 == a1)) ? wd3 : mem[a1];
        busy1 = pend[a1] && !(we3 && (a3 == a1));
      end
      if (a2 != '0) begin
        rd2   = (we3 && (a3 == a2)) ? wd3 : mem[a2];
        busy2 = pend[a2] && !(we3 && (a3 == a2));
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [4:0]  a1, a2, a3, iss_rd;
  logic [31:0] rd1, rd2, wd3;
  logic        busy1, busy2, we3, iss_v;
  logic [5:0]  pend_cnt;

  int tests = 0;
  int failed = 0;

  regfile_sb #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we3(we3), .a3(a3), .wd3(wd3),
    .iss_v(iss_v), .iss_rd(iss_rd), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, pending set, remaining clear cycles.
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  int          m_clear;

  function automatic int m_cnt();
    int n = 0;
    for (int i = 1; i < 32; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (m_clear != 0 || a == 0) return 32'd0;
    if (we3 && a3 == a) return wd3;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (m_clear != 0 || a == 0) return 1'b0;
    return m_pend[a] && !(we3 && a3 == a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ir, input logic [4:0] x1, input logic [4:0] x2);
    rst = r; we3 = we; a3 = wa; wd3 = wd; iss_v = iv; iss_rd = ir; a1 = x1; a2 = x2;
  endtask

  task automatic check_model();
    @(negedge clk);
    chk("ready", 64'(ready), 64'(m_clear == 0));
    chk("rd1", 64'(rd1), 64'(exp_rd(a1)));
    chk("rd2", 64'(rd2), 64'(exp_rd(a2)));
    chk("busy1", 64'(busy1), 64'(exp_busy(a1)));
    chk("busy2", 64'(busy2), 64'(exp_busy(a2)));
    chk("pend_cnt", 64'(pend_cnt), 64'(m_cnt()));
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (rst) begin
      m_clear = 31;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else if (m_clear > 0) begin
      m_reg[32 - m_clear] = 32'd0;
      m_clear--;
    end else begin
      if (we3 && a3 != 0) begin
        m_reg[a3] = wd3;
        m_pend[a3] = 0;
      end
      if (iss_v && iss_rd != 0) m_pend[iss_rd] = 1;
    end
    #1;
  endtask

  // Counts edges until ready rises (bounded); expects the full clear length.
  task automatic wait_ready(input string nm, input bit rand_in);
    int n = 0;
    while (!ready && n < 100) begin
      if (rand_in)
        drive(0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_model();
      edge_update();
      n++;
    end
    chk(nm, 64'(n), 64'd31);
  endtask

  typedef struct {
    logic we; logic [4:0] a3; logic [31:0] wd;
    logic iv; logic [4:0] ir; logic [4:0] a1;
    logic [31:0] e_rd1; logic e_busy1; int e_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_pend[i] = 0; end
    m_clear = 31;
    tbl[0]  = '{1, 1, 32'd42,     0, 0, 1, 32'd42,     0, 0};
    tbl[1]  = '{0, 0, 32'd0,      0, 0, 1, 32'd42,     0, 0};
    tbl[2]  = '{1, 0, 32'd99,     1, 0, 0, 32'd0,      0, 0};
    tbl[3]  = '{0, 0, 32'd0,      1, 5, 5, 32'd0,      0, 1};
    tbl[4]  = '{0, 0, 32'd0,      1, 7, 5, 32'd0,      1, 2};
    tbl[5]  = '{1, 5, 32'd7,      0, 0, 5, 32'd7,      0, 1};
    tbl[6]  = '{0, 0, 32'd0,      1, 3, 3, 32'd0,      0, 2};
    tbl[7]  = '{1, 3, 32'hDEAD,   1, 3, 3, 32'hDEAD,   0, 2};
    tbl[8]  = '{0, 0, 32'd0,      0, 0, 3, 32'hDEAD,   1, 2};
    tbl[9]  = '{0, 0, 32'd0,      1, 3, 3, 32'hDEAD,   1, 2};
    tbl[10] = '{1, 3, 32'd1,      0, 0, 3, 32'd1,      0, 1};
    tbl[11] = '{1, 9, 32'd5,      0, 0, 9, 32'd5,      0, 1};
    tbl[12] = '{0, 0, 32'd0,      0, 0, 7, 32'd0,      1, 1};

    // Power-up reset then initial clear sequence.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    edge_update();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    wait_ready("init_clear_cycles", 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      check_model();
      chk("init_zero", 64'(rd1), 64'd0);
      edge_update();
    end

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      drive(0, tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].iv, tbl[i].ir, tbl[i].a1, tbl[i].a1);
      check_model();
      chk($sformatf("vec%0d_rd1", i), 64'(rd1), 64'(tbl[i].e_rd1));
      chk($sformatf("vec%0d_busy1", i), 64'(busy1), 64'(tbl[i].e_busy1));
      edge_update();
      chk($sformatf("vec%0d_cnt", i), 64'(pend_cnt), 64'(tbl[i].e_cnt));
    end

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drive(0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      check_model();
      edge_update();
    end

    // Reset mid-RUN with exactly three registers pending.
    for (int i = 1; i < 32; i++) begin
      drive(0, 1, 5'(i), 32'(i * 3 + 1), 0, 0, 5'(i), 0);
      check_model();
      edge_update();
    end
    for (int i = 10; i < 13; i++) begin
      drive(0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
      check_model();
      edge_update();
    end
    chk("pre_rst_cnt", 64'(pend_cnt), 64'd3);
    drive(1, 0, 0, 0, 0, 0, 11, 12);
    check_model();
    edge_update();
    chk("mid_rst_ready", 64'(ready), 64'd0);
    chk("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    wait_ready("reclear_cycles", 1);
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(i));
      check_model();
      chk("reclear_zero", 64'(rd1), 64'd0);
      edge_update();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
